// File: rtl/bus_ram_ctl_if.sv
// bus_ram_ctl_if
//   Command and status signals between the CPU and the shared-bus RAM controller.
//   The tri-state data bus stays a plain inout port on the controller, so the
//   interface carries only unidirectional signals.
//
//   Handshake: a command (iram, eram, iaddr, inc, err_clr) is accepted at a rising
//   clock edge only while ready=1. Commands presented while ready=0 are dropped,
//   not held. Once ready rises it stays high until reset, so the CPU never has
//   to wait after initialisation.
//
//   Signals:
//     iram      master->slave  write bus word to mem[o_addr]
//     eram      master->slave  drive mem[o_addr] onto the data bus
//     iaddr     master->slave  load the address register from the bus
//     inc       master->slave  post-increment the address after an accepted iram/eram
//     err_clr   master->slave  clear the sticky error flag
//     o_addr    slave->master  current address register
//     ready     slave->master  controller accepts commands
//     err       slave->master  sticky out-of-range/conflict flag
//     dbg_state slave->master  FSM state (0 = INIT, 1 = READY)
interface bus_ram_ctl_if #(
    parameter int ADDR_W = 7
);
    logic              iram;
    logic              eram;
    logic              iaddr;
    logic              inc;
    logic              err_clr;
    logic [ADDR_W-1:0] o_addr;
    logic              ready;
    logic              err;
    logic              dbg_state;

    modport master (
        output iram, eram, iaddr, inc, err_clr,
        input  o_addr, ready, err, dbg_state
    );

    modport slave (
        input  iram, eram, iaddr, inc, err_clr,
        output o_addr, ready, err, dbg_state
    );
endinterface

// File: rtl/bus_ram_ctl.sv
// bus_ram_ctl
//   Single-port RAM on the tri-state CPU data bus with an address register loaded
//   from the bus, a prefetched registered read path, post-increment addressing
//   wrapping at DEPTH, a sticky error flag for out-of-range loads and read/write
//   conflicts, and an optional power-on clear of the whole array.
//
//   Ports:
//     clk    system clock, all state on the rising edge
//     rst_n  asynchronous active-low reset
//     bus    command/status interface (slave side)
//     data   shared CPU data bus, driven only while eram=1 and ready=1
module bus_ram_ctl #(
    parameter int DATA_W     = 16,
    parameter int DEPTH      = 128,
    parameter int ADDR_W     = 7,
    parameter int INIT_CLEAR = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    bus_ram_ctl_if.slave      bus,
    inout  wire  [DATA_W-1:0] data
);
    typedef enum logic {ST_INIT = 1'b0, ST_READY = 1'b1} state_t;

    localparam logic [ADDR_W-1:0] LAST      = ADDR_W'(DEPTH - 1);
    localparam logic [DATA_W:0]   DEPTH_CMP = (DATA_W + 1)'(DEPTH);

    state_t            state;
    logic              ready_q;
    logic              err_q;
    logic [ADDR_W-1:0] addr;
    logic [ADDR_W-1:0] clr_ptr;
    logic [DATA_W-1:0] rd_q;
    logic [DATA_W-1:0] mem [DEPTH];

    logic              in_range;
    logic              accept;
    logic              conflict;
    logic              wr_en;
    logic              load_ok;
    logic              load_bad;
    logic              step_en;
    logic              clr_en;
    logic [ADDR_W-1:0] addr_inc;
    logic [ADDR_W-1:0] addr_next;
    logic [DATA_W-1:0] rd_next;

    always_comb begin
        // Full-width compare: a bus value with bits set above ADDR_W is out of range.
        in_range = {1'b0, data} < DEPTH_CMP;
        accept   = ready_q & (bus.iram | bus.eram);
        conflict = ready_q & bus.iram & bus.eram;
        wr_en    = ready_q & bus.iram & ~bus.eram;
        load_ok  = ready_q & bus.iaddr & in_range;
        load_bad = ready_q & bus.iaddr & ~in_range;
        // iaddr blocks the increment even when the load itself is rejected.
        step_en  = accept & bus.inc & ~bus.iaddr;
        clr_en   = (INIT_CLEAR != 0) && (state == ST_INIT);
        addr_inc = (addr == LAST) ? '0 : addr + ADDR_W'(1);

        addr_next = addr;
        if (load_ok) begin
            addr_next = data[ADDR_W-1:0];
        end else if (step_en) begin
            addr_next = addr_inc;
        end

        // Prefetch the word the address register will point at after this edge,
        // forwarding a same-edge write so the bus never shows stale data.
        rd_next = mem[addr_next];
        if (wr_en && (addr == addr_next)) begin
            rd_next = data;
        end else if (clr_en && (clr_ptr == addr_next)) begin
            rd_next = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_INIT;
            ready_q <= 1'b0;
            err_q   <= 1'b0;
            addr    <= '0;
            clr_ptr <= '0;
            rd_q    <= '0;
        end else begin
            rd_q <= rd_next;
            addr <= addr_next;
            if (conflict || load_bad) begin
                err_q <= 1'b1;
            end else if (ready_q && bus.err_clr) begin
                err_q <= 1'b0;
            end
            case (state)
                ST_INIT: begin
                    if ((INIT_CLEAR == 0) || (clr_ptr == LAST)) begin
                        state   <= ST_READY;
                        ready_q <= 1'b1;
                    end else begin
                        clr_ptr <= clr_ptr + ADDR_W'(1);
                    end
                end
                ST_READY: begin
                    ready_q <= 1'b1;
                end
            endcase
        end
    end

    // Array has no reset; clearing is done by the INIT sweep once reset is released.
    always_ff @(posedge clk) begin
        if (rst_n && clr_en) begin
            mem[clr_ptr] <= '0;
        end else if (wr_en) begin
            mem[addr] <= data;
        end
    end

    assign data          = (bus.eram && ready_q) ? rd_q : {DATA_W{1'bz}};
    assign bus.o_addr    = addr;
    assign bus.ready     = ready_q;
    assign bus.err       = err_q;
    assign bus.dbg_state = state;
endmodule
